// File: rtl/generic_pipe_reg.sv
// rtl/generic_pipe_reg.sv - elastic valid/ready pipeline register chain with flush, enable and occupancy count
//
// Purpose:
//   DEPTH stages of WIDTH-bit opaque data, each with its own valid bit.
//   Empty stages (bubbles) accept upstream data even when the output is
//   stalled, so the chain can fill completely under backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   en         global enable; low freezes all state and blocks handshakes
//   flush      synchronous clear of every valid bit (data registers keep their value)
//   in_valid   upstream word valid
//   in_data    upstream word
//   in_ready   chain accepts in_data this cycle
//   out_valid  last stage holds a valid word
//   out_data   last stage data (not gated by out_valid)
//   out_ready  downstream accepts out_data this cycle
//   count      number of stages currently holding a valid word

module generic_pipe_reg #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic [DEPTH-1:0] rdy;
    logic             full_tail;
    logic [DEPTH:0]   src_v;
    logic [WIDTH-1:0] src_d [DEPTH+1];

    // A stage may load whenever the output is taking a word or any stage at or
    // after it is empty. Walking from the output side with a running AND of the
    // valid bits gives that without a self-referencing ready vector.
    always_comb begin
        full_tail = 1'b1;
        rdy       = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            full_tail = full_tail & v_q[i];
            rdy[i]    = out_ready | ~full_tail;
        end
    end

    // Source of stage i is entry i of these vectors: entry 0 is the chain input,
    // entry i+1 is stage i.
    always_comb begin
        src_v    = {v_q, in_valid};
        src_d[0] = in_data;
        for (int i = 0; i < DEPTH; i++) begin
            src_d[i+1] = d_q[i];
        end
    end

    always_comb begin
        v_d = v_q;
        for (int i = 0; i < DEPTH; i++) begin
            d_d[i] = d_q[i];
        end

        if (en) begin
            if (flush) begin
                // Flush wins over every transfer, including the input word.
                v_d = '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rdy[i]) begin
                        v_d[i] = src_v[i];
                        // Data only moves with a valid word, so an empty stage
                        // keeps its last value.
                        if (src_v[i]) begin
                            d_d[i] = src_d[i];
                        end
                    end
                end
            end
        end

        // Occupancy is registered alongside the valid bits so it is always in
        // step with them.
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CNT_W'(v_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign in_ready  = en & rdy[0];
    assign out_valid = en & v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_generic_pipe_reg.sv
// tb/tb_generic_pipe_reg.sv - self-checking bench for generic_pipe_reg

module tb_generic_pipe_reg;

    localparam int W  = 13;
    localparam int D  = 3;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          flush;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    // Reference model: a row of slots plus an in-order scoreboard of accepted words.
    logic         m_v [D];
    logic [W-1:0] m_d [D];
    logic [W-1:0] exp_q [$];

    generic_pipe_reg #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < D; i++) c += int'(m_v[i]);
        return c;
    endfunction

    // The chain refuses input only when every slot is occupied and nothing leaves.
    function automatic logic m_in_ready();
        return en && ((m_count() < D) || out_ready);
    endfunction

    function automatic logic m_out_valid();
        return en && m_v[D-1];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        exp_q.delete();
    endtask

    // Advance one clock and apply the chain's rules to the model: the leaving word
    // goes, every word with a hole somewhere ahead moves one slot, a new word enters.
    task automatic tick();
        logic acc_in;
        logic acc_out;
        @(posedge clk);
        if (en) begin
            if (flush) begin
                for (int i = 0; i < D; i++) m_v[i] = 1'b0;
                exp_q.delete();
            end else begin
                acc_in  = in_valid && m_in_ready();
                acc_out = m_v[D-1] && out_ready;
                if (acc_out) begin
                    m_v[D-1] = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                for (int i = D - 1; i >= 1; i--) begin
                    if (!m_v[i] && m_v[i-1]) begin
                        m_v[i]   = 1'b1;
                        m_d[i]   = m_d[i-1];
                        m_v[i-1] = 1'b0;
                    end
                end
                if (acc_in) begin
                    m_v[0] = 1'b1;
                    m_d[0] = in_data;
                    exp_q.push_back(in_data);
                end
            end
        end
        #1;
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
    endtask

    task automatic test_reset();
        model_clear();
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || count !== '0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_init got ov=%0b od=%h cnt=%0d ir=%0b want ov=0 od=0 cnt=0 ir=1",
                     out_valid, out_data, count, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, W'(k + 7), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        #1;
        total++;
        if (count !== CW'(3) || out_data !== W'(7)) begin
            bad++;
            $display("FAIL reset_prefill got cnt=%0d od=%h want cnt=3 od=0007", count, out_data);
        end
        // Asynchronous pulse in the middle of a cycle, checked before any clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || count !== '0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_async got ov=%0b od=%h cnt=%0d ir=%0b want ov=0 od=0 cnt=0 ir=1",
                     out_valid, out_data, count, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        logic [W-1:0] sw [3];
        logic [W-1:0] obs [$];
        int first_seen;
        int last_seen;
        int peak;
        sw[0] = 13'h0005;
        sw[1] = 13'h1FFB;
        sw[2] = 13'h0FFF;
        first_seen = -1;
        last_seen  = -1;
        peak       = 0;
        for (int t = 0; t < 8; t++) begin
            if (t < 3) drive(1'b1, sw[t], 1'b1);
            else       drive(1'b0, '0, 1'b1);
            #1;
            if (out_valid) begin
                obs.push_back(out_data);
                if (first_seen < 0) first_seen = t;
                last_seen = t;
            end
            if (int'(count) > peak) peak = int'(count);
            tick();
        end
        total++;
        if (first_seen != 3 || last_seen != 5) begin
            bad++;
            $display("FAIL stream_latency got first=%0d last=%0d want first=3 last=5", first_seen, last_seen);
        end
        total++;
        if (obs.size() != 3) begin
            bad++;
            $display("FAIL stream_len got %0d want 3", obs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (obs[i] !== sw[i]) begin
                    bad++;
                    $display("FAIL stream_word%0d got %h want %h", i, obs[i], sw[i]);
                end
            end
        end
        total++;
        if (peak != 3) begin
            bad++;
            $display("FAIL stream_peak got %0d want 3", peak);
        end
    endtask

    task automatic test_stall_bubble();
        drive(1'b1, W'(1), 1'b0); tick();
        drive(1'b0, '0,    1'b0); tick();
        drive(1'b1, W'(2), 1'b0); tick();
        drive(1'b1, W'(3), 1'b0); tick();
        drive(1'b1, W'(4), 1'b0);
        #1;
        total++;
        if (count !== CW'(3)) begin
            bad++;
            $display("FAIL stall_count got %0d want 3", count);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_in_ready got %0b want 0", in_ready);
        end
        tick();
        for (int j = 1; j <= 3; j++) begin
            drive(1'b0, '0, 1'b1);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== W'(j)) begin
                bad++;
                $display("FAIL stall_drain%0d got ov=%0b od=%h want ov=1 od=%h", j, out_valid, out_data, W'(j));
            end
            tick();
        end
        total++;
        if (count !== '0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_empty got cnt=%0d ov=%0b want cnt=0 ov=0", count, out_valid);
        end
    endtask

    task automatic test_full_simul();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, W'(10 + k), 1'b0);
            tick();
        end
        drive(1'b1, W'(13), 1'b1);
        #1;
        total++;
        if (count !== CW'(3) || in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== W'(10)) begin
            bad++;
            $display("FAIL full_simul got cnt=%0d ir=%0b ov=%0b od=%h want cnt=3 ir=1 ov=1 od=000a",
                     count, in_ready, out_valid, out_data);
        end
        tick();
        drive(1'b1, W'(14), 1'b1);
        #1;
        total++;
        if (count !== CW'(3) || in_ready !== 1'b1 || out_data !== W'(11)) begin
            bad++;
            $display("FAIL full_keep got cnt=%0d ir=%0b od=%h want cnt=3 ir=1 od=000b", count, in_ready, out_data);
        end
        tick();
        for (int j = 12; j <= 14; j++) begin
            drive(1'b0, '0, 1'b1);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== W'(j)) begin
                bad++;
                $display("FAIL full_drain got ov=%0b od=%h want ov=1 od=%h", out_valid, out_data, W'(j));
            end
            tick();
        end
    endtask

    task automatic test_flush();
        drive(1'b1, W'(20), 1'b0); tick();
        drive(1'b1, W'(21), 1'b0); tick();
        drive(1'b1, W'(22), 1'b0);
        flush = 1'b1;
        #1;
        total++;
        if (count !== CW'(2)) begin
            bad++;
            $display("FAIL flush_pre got %0d want 2", count);
        end
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 1'b1);
        #1;
        total++;
        if (count !== '0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_post got cnt=%0d ov=%0b want cnt=0 ov=0", count, out_valid);
        end
        for (int t = 0; t < 4; t++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_leak cycle%0d got ov=%0b od=%h want ov=0", t, out_valid, out_data);
            end
        end
    endtask

    task automatic test_enable_freeze();
        logic [W-1:0] got [$];
        drive(1'b1, W'(30), 1'b0); tick();
        drive(1'b1, W'(31), 1'b0); tick();
        drive(1'b1, W'(99), 1'b1);
        en = 1'b0;
        for (int t = 0; t < 4; t++) begin
            flush = (t == 1);
            #1;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== CW'(2)) begin
                bad++;
                $display("FAIL freeze cycle%0d got ov=%0b ir=%0b cnt=%0d want ov=0 ir=0 cnt=2",
                         t, out_valid, in_ready, count);
            end
            tick();
        end
        flush = 1'b0;
        en    = 1'b1;
        drive(1'b0, '0, 1'b1);
        for (int t = 0; t < 10 && got.size() < 2; t++) begin
            #1;
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
        end
        total++;
        if (got.size() != 2) begin
            bad++;
            $display("FAIL freeze_resume got %0d words want 2", got.size());
        end else begin
            total++;
            if (got[0] !== W'(30) || got[1] !== W'(31)) begin
                bad++;
                $display("FAIL freeze_order got %h,%h want 001e,001f", got[0], got[1]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            en       = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            in_valid = $urandom_range(0, 1);
            in_data  = W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            total++;
            if (in_ready !== m_in_ready() || out_valid !== m_out_valid() || count !== CW'(m_count())
                || out_data !== m_d[D-1]) begin
                bad++;
                $display("FAIL rand cycle%0d got ir=%0b ov=%0b cnt=%0d od=%h want ir=%0b ov=%0b cnt=%0d od=%h",
                         t, in_ready, out_valid, count, out_data,
                         m_in_ready(), m_out_valid(), m_count(), m_d[D-1]);
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_sb cycle%0d got od=%h want no word", t, out_data);
                end else if (out_data !== exp_q[0]) begin
                    bad++;
                    $display("FAIL rand_sb cycle%0d got od=%h want %h", t, out_data, exp_q[0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_stall_bubble();
        test_full_simul();
        test_flush();
        test_enable_freeze();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
